bf_io_port: RTL and testbench

Byte-wide console responder on the CPU's `io_*` request/acknowledge bus. Accepts CPU `.` writes into a TX FIFO drained by a valid/ready byte stream, and serves CPU `,` reads from an RX FIFO filled by a second valid/ready stream. Sits between the CPU core and a UART or testbench console. Stalls the CPU by withholding `io_ack` until the FIFO can satisfy the request.

---
 rtl/bf_io_port.sv | 214 +++++++++++++++++++++
 tb/tb_bf_io_port.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_io_port.sv
// bf_io_port: byte-wide console responder on the CPU io_* request/ack bus.
//
// CPU writes ('.') are pushed into a TX FIFO. The TX FIFO is drained by a
// valid/ready stream (tx_*). CPU reads (',') pop an RX FIFO. The RX FIFO is
// filled by a second valid/ready stream (rx_*). The CPU is stalled by
// withholding io_ack until the selected FIFO can satisfy the request.
//
// Stream handshake: a byte moves on an edge where valid && ready are both high.
// Valid must not depend on ready. Both tx_valid and rx_ready decode registered
// occupancy only.
//
// Optional feature, macro BF_IO_NONBLOCK_READ_EN:
//   defined   - a read that arrives in IDLE while RX is empty completes at once
//               with io_rdata = 8'h00 (EOF). Writes still block.
//   undefined - a read on an empty RX waits in WAIT until a byte arrives.
//
// The FSM state is held in state_q (IDLE / WAIT / ACK / RELEASE), so a
// checker can bind to it hierarchically.

module bf_io_port #(
    parameter int tx_depth_log2 = 4,
    parameter int rx_depth_log2 = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   io_req,
    input  logic                   io_dir,
    input  logic [7:0]             io_wdata,
    output logic                   io_ack,
    output logic [7:0]             io_rdata,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    output logic [tx_depth_log2:0] tx_count,
    output logic [rx_depth_log2:0] rx_count
);

    // Direction encoding shared with the CPU core.
    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    localparam int TX_DEPTH = 1 << tx_depth_log2;
    localparam int RX_DEPTH = 1 << rx_depth_log2;
    localparam int TX_CW    = tx_depth_log2 + 1;
    localparam int RX_CW    = rx_depth_log2 + 1;

    localparam logic [tx_depth_log2-1:0] TX_PTR_ONE = tx_depth_log2'(1);
    localparam logic [rx_depth_log2-1:0] RX_PTR_ONE = rx_depth_log2'(1);
    localparam logic [tx_depth_log2:0]   TX_CNT_ONE = TX_CW'(1);
    localparam logic [rx_depth_log2:0]   RX_CNT_ONE = RX_CW'(1);
    localparam logic [tx_depth_log2:0]   TX_FULL    = TX_CW'(TX_DEPTH);
    localparam logic [rx_depth_log2:0]   RX_FULL    = RX_CW'(RX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Registered state
    state_t                   state_q, state_d;
    logic                     io_ack_q, io_ack_d;
    logic [7:0]               io_rdata_q, io_rdata_d;

    logic [tx_depth_log2-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [tx_depth_log2-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [tx_depth_log2:0]   tx_count_q, tx_count_d;
    logic [7:0]               tx_mem_q [TX_DEPTH];

    logic [rx_depth_log2-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [rx_depth_log2-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [rx_depth_log2:0]   rx_count_q, rx_count_d;
    logic [7:0]               rx_mem_q [RX_DEPTH];

    // Per-cycle decisions
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic serve, wr_go, rd_go, rd_eof;

    // Occupancy flags and stream-side handshakes, all from registered counts.
    always_comb begin
        tx_empty = (tx_count_q == '0);
        tx_full  = (tx_count_q == TX_FULL);
        rx_empty = (rx_count_q == '0);
        rx_full  = (rx_count_q == RX_FULL);
        tx_pop   = !tx_empty && tx_ready;
        rx_push  = !rx_full && rx_valid;
    end

    // Request service decision and FSM next state.
    always_comb begin
        // A request is only eligible while the FSM is waiting for one.
        serve  = io_req && ((state_q == S_IDLE) || (state_q == S_WAIT));
        // A full TX FIFO still accepts a write on an edge where the head pops.
        wr_go  = serve && (io_dir == DIRECTION_WRITE) && (!tx_full || tx_pop);
        rd_go  = serve && (io_dir == DIRECTION_READ) && !rx_empty;
`ifdef BF_IO_NONBLOCK_READ_EN
        rd_eof = io_req && (state_q == S_IDLE) && (io_dir == DIRECTION_READ) && rx_empty;
`else
        rd_eof = 1'b0;
`endif
        tx_push = wr_go;
        rx_pop  = rd_go;

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (io_req) begin
                    state_d = (wr_go || rd_go || rd_eof) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                // A dropped request abandons the transfer without an ack.
                if (!io_req) begin
                    state_d = S_IDLE;
                end else if (wr_go || rd_go) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold off until the CPU drops the request it was acked for.
                if (!io_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        io_ack_d   = (state_d == S_ACK);
        io_rdata_d = io_rdata_q;
        if (rd_go) begin
            io_rdata_d = rx_mem_q[rx_rd_ptr_q];
        end else if (rd_eof) begin
            io_rdata_d = 8'h00;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        tx_wr_ptr_d = tx_push ? (tx_wr_ptr_q + TX_PTR_ONE) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? (tx_rd_ptr_q + TX_PTR_ONE) : tx_rd_ptr_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase

        rx_wr_ptr_d = rx_push ? (rx_wr_ptr_q + RX_PTR_ONE) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? (rx_rd_ptr_q + RX_PTR_ONE) : rx_rd_ptr_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
    end

    // FSM, registered outputs and FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            io_ack_q    <= 1'b0;
            io_rdata_q  <= 8'h00;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            io_ack_q    <= io_ack_d;
            io_rdata_q  <= io_rdata_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // TX storage; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= io_wdata;
        end
    end

    // RX storage; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_data;
        end
    end

    // tx_data is forced to zero while empty so stale storage never shows.
    assign io_ack   = io_ack_q;
    assign io_rdata = io_rdata_q;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
    assign rx_ready = !rx_full;
    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;

endmodule

// File: tb/tb_bf_io_port.sv
// Self-checking bench for bf_io_port (both FIFOs 4 deep).
// Directed scenarios first, then a randomized phase checked every cycle
// against a queue-based model of the two FIFOs and the CPU transaction rules.

module tb_bf_io_port;

    localparam int   TXL = 2;
    localparam int   RXL = 2;
    localparam int   TXD = 4;
    localparam int   RXD = 4;
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           io_req = 1'b0;
    logic           io_dir = 1'b0;
    logic [7:0]     io_wdata = 8'h00;
    logic           io_ack;
    logic [7:0]     io_rdata;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b0;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_ready;
    logic [TXL:0]   tx_count;
    logic [RXL:0]   rx_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    bf_io_port #(.tx_depth_log2(TXL), .rx_depth_log2(RXL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_req   (io_req),
        .io_dir   (io_dir),
        .io_wdata (io_wdata),
        .io_ack   (io_ack),
        .io_rdata (io_rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_count (tx_count),
        .rx_count (rx_count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full cycle; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},      32'(io_ack),   32'd0);
        check({tag, "_rdata"},    32'(io_rdata), 32'h00);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"},  32'(tx_data),  32'h00);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_tx_count"}, 32'(tx_count), 32'd0);
        check({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    endtask

    task automatic do_reset();
        io_req   = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
    endtask

    // CPU transfer: raise the request, wait (bounded) for the ack, confirm it is
    // a single-cycle pulse, then drop the request and leave two idle cycles.
    // lat = cycles from request to ack, or -1 if the ack never came.
    task automatic cpu_xfer(input logic dir, input logic [7:0] d, input int max_cyc,
                            input string tag, output int lat);
        io_req   = 1'b1;
        io_dir   = dir;
        io_wdata = d;
        lat      = 0;
        while (lat < max_cyc) begin
            tick();
            lat++;
            if (io_ack === 1'b1) break;
        end
        if (io_ack !== 1'b1) begin
            lat = -1;
        end
        io_req = 1'b0;
        tick();
        if (lat > 0) begin
            check({tag, "_ack_pulse"}, 32'(io_ack), 32'd0);
        end
        tick();
    endtask

    // Drain the TX stream and compare each byte against exp_q.
    task automatic drain_tx(input string tag);
        logic [7:0] e;
        tx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_tx_data"}, 32'(tx_data), 32'(e));
            tick();
        end
        tx_ready = 1'b0;
        check({tag, "_tx_empty"}, 32'(tx_count), 32'd0);
    endtask

    // Randomized-phase model state
    logic [7:0] m_tx_q[$];
    logic [7:0] m_rx_q[$];
    logic       m_ack;
    logic [7:0] m_rdata;
    logic       pend;
    logic       fresh;
    int         gap;

    initial begin
        int lat;
        int acks;
        int txs, rxs;
        logic pop_tx, push_rx, acc_wr, acc_rd;

        // ---- reset values ----
        do_reset();

        // ---- single write into empty TX ----
        cpu_xfer(DIR_WRITE, 8'h41, 8, "t2", lat);
        check("t2_latency", 32'(lat), 32'd1);
        check("t2_tx_valid", 32'(tx_valid), 32'd1);
        check("t2_tx_data", 32'(tx_data), 32'h41);
        check("t2_tx_count", 32'(tx_count), 32'd1);
        exp_q.push_back(8'h41);
        drain_tx("t2");

        // ---- fill TX, blocked fifth write released by one pop ----
        for (int i = 0; i < 4; i++) begin
            cpu_xfer(DIR_WRITE, 8'(i + 1), 8, "t3_fill", lat);
            check("t3_fill_latency", 32'(lat), 32'd1);
        end
        check("t3_full_count", 32'(tx_count), 32'd4);
        io_req   = 1'b1;
        io_dir   = DIR_WRITE;
        io_wdata = 8'h05;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (io_ack === 1'b1) acks++;
        end
        check("t3_no_ack_full", 32'(acks), 32'd0);
        check("t3_still_full", 32'(tx_count), 32'd4);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("t3_ack_after_pop", 32'(io_ack), 32'd1);
        check("t3_count_after", 32'(tx_count), 32'd4);
        check("t3_head_after", 32'(tx_data), 32'h02);
        io_req = 1'b0;
        tick();
        tick();
        for (int i = 2; i <= 5; i++) exp_q.push_back(8'(i));
        drain_tx("t3");

        // ---- RX push two, read two ----
        rx_valid = 1'b1;
        rx_data  = 8'h30;
        tick();
        rx_data  = 8'h31;
        tick();
        rx_valid = 1'b0;
        check("t4_rx_count", 32'(rx_count), 32'd2);
        cpu_xfer(DIR_READ, 8'h00, 8, "t4a", lat);
        check("t4a_latency", 32'(lat), 32'd1);
        check("t4a_rdata", 32'(io_rdata), 32'h30);
        cpu_xfer(DIR_READ, 8'h00, 8, "t4b", lat);
        check("t4b_rdata", 32'(io_rdata), 32'h31);
        check("t4_rx_empty", 32'(rx_count), 32'd0);

        // ---- read on empty RX ----
`ifdef BF_IO_NONBLOCK_READ_EN
        cpu_xfer(DIR_READ, 8'h00, 8, "t5", lat);
        check("t5_eof_latency", 32'(lat), 32'd1);
        check("t5_eof_rdata", 32'(io_rdata), 32'h00);
`else
        io_req = 1'b1;
        io_dir = DIR_READ;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (io_ack === 1'b1) acks++;
        end
        check("t5_no_ack_empty", 32'(acks), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h7a;
        tick();
        rx_valid = 1'b0;
        lat = 1;
        while (io_ack !== 1'b1 && lat < 4) begin
            tick();
            lat++;
        end
        check("t5_ack_within_2", 32'(lat <= 2), 32'd1);
        check("t5_rdata", 32'(io_rdata), 32'h7a);
        io_req = 1'b0;
        tick();
        tick();
        check("t5_rdata_held", 32'(io_rdata), 32'h7a);
        check("t5_rx_count", 32'(rx_count), 32'd0);
`endif

        // ---- request held high after the ack ----
        io_req   = 1'b1;
        io_dir   = DIR_WRITE;
        io_wdata = 8'h55;
        tick();
        check("t6_ack", 32'(io_ack), 32'd1);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (io_ack === 1'b1) acks++;
        end
        check("t6_single_ack", 32'(acks), 32'd0);
        check("t6_single_push", 32'(tx_count), 32'd1);
        io_req = 1'b0;
        tick();
        tick();
        cpu_xfer(DIR_WRITE, 8'h56, 8, "t6b", lat);
        check("t6b_latency", 32'(lat), 32'd1);
        check("t6b_count", 32'(tx_count), 32'd2);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h56);
        drain_tx("t6");

        // ---- reset while stalled in WAIT ----
        for (int i = 0; i < 3; i++) begin
            cpu_xfer(DIR_WRITE, 8'(8'ha1 + i), 8, "t7_fill", lat);
        end
`ifdef BF_IO_NONBLOCK_READ_EN
        cpu_xfer(DIR_WRITE, 8'ha4, 8, "t7_fill", lat);
        io_req   = 1'b1;
        io_dir   = DIR_WRITE;
        io_wdata = 8'ha5;
`else
        io_req = 1'b1;
        io_dir = DIR_READ;
`endif
        tick();
        tick();
        check("t7_stalled", 32'(io_ack), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t7_rst_ack", 32'(io_ack), 32'd0);
        check("t7_rst_tx_count", 32'(tx_count), 32'd0);
        check("t7_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("t7_rst_rx_ready", 32'(rx_ready), 32'd1);
        io_req = 1'b0;
        tick();
        check("t7_rst_no_ack", 32'(io_ack), 32'd0);
        rst_n = 1'b1;
        tick();
        cpu_xfer(DIR_WRITE, 8'h66, 8, "t7_after", lat);
        check("t7_after_latency", 32'(lat), 32'd1);
        check("t7_after_count", 32'(tx_count), 32'd1);
        check("t7_after_data", 32'(tx_data), 32'h66);

        // ---- randomized phase against the queue model ----
        do_reset();
        m_tx_q.delete();
        m_rx_q.delete();
        m_ack   = 1'b0;
        m_rdata = 8'h00;
        pend    = 1'b0;
        fresh   = 1'b0;
        gap     = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // compare DUT against the model state after the last edge
            check("rnd_ack", 32'(io_ack), 32'(m_ack));
            check("rnd_rdata", 32'(io_rdata), 32'(m_rdata));
            check("rnd_tx_count", 32'(tx_count), 32'(m_tx_q.size()));
            check("rnd_rx_count", 32'(rx_count), 32'(m_rx_q.size()));
            check("rnd_tx_valid", 32'(tx_valid), 32'(m_tx_q.size() > 0));
            check("rnd_rx_ready", 32'(rx_ready), 32'(m_rx_q.size() < RXD));
            check("rnd_tx_data", 32'(tx_data),
                  (m_tx_q.size() > 0) ? 32'(m_tx_q[0]) : 32'h0);

            // CPU driver: drop after the ack, then stay low for at least two edges
            if (gap > 0) gap--;
            if (m_ack) begin
                io_req = 1'b0;
                gap    = 2;
            end else if (!io_req && gap == 0 && $urandom_range(0, 2) == 0) begin
                io_req   = 1'b1;
                io_dir   = 1'($urandom_range(0, 1));
                io_wdata = 8'($urandom_range(0, 255));
                pend     = 1'b1;
                fresh    = 1'b1;
            end
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom_range(0, 255));

            // model of the coming edge
            txs     = m_tx_q.size();
            rxs     = m_rx_q.size();
            pop_tx  = tx_ready && (txs > 0);
            push_rx = rx_valid && (rxs < RXD);
            acc_wr  = pend && io_req && (io_dir == DIR_WRITE) && ((txs < TXD) || pop_tx);
`ifdef BF_IO_NONBLOCK_READ_EN
            acc_rd  = pend && io_req && (io_dir == DIR_READ) && ((rxs > 0) || fresh);
`else
            acc_rd  = pend && io_req && (io_dir == DIR_READ) && (rxs > 0);
`endif
            if (pop_tx) void'(m_tx_q.pop_front());
            if (acc_rd) m_rdata = (rxs > 0) ? m_rx_q.pop_front() : 8'h00;
            if (acc_wr) m_tx_q.push_back(io_wdata);
            if (push_rx) m_rx_q.push_back(rx_data);
            m_ack = acc_wr || acc_rd;
            if (m_ack) pend = 1'b0;
            fresh = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
